// File: rtl/zorro2_autoconfig_multi.sv
`default_nettype none
// ============================================================================
// zorro2_autoconfig_multi -- Zorro II autoconfig responder that presents
// NUM_BOARDS logical boards one after another on the config chain.
// Revision: 1.0
// ============================================================================
module zorro2_autoconfig_multi #(
  parameter int                      NUM_BOARDS = 2,
  parameter logic [8*NUM_BOARDS-1:0] ER_TYPE    = {8'hC1, 8'hC6},
  parameter logic [8*NUM_BOARDS-1:0] PRODUCT    = {8'h02, 8'h01},
  parameter logic [15:0]             MANUF      = 16'h0815,
  parameter logic [31:0]             SERIAL     = 32'h0
) (
  input  logic                    mclk,
  input  logic                    reset,
  input  logic [23:1]             a,
  input  logic                    as_n,
  input  logic                    uds_n,
  input  logic                    lds_n,
  input  logic                    rw,
  input  logic [15:0]             d_in,
  input  logic                    cfgin_n,
  output logic [15:0]             d_out,
  output logic                    d_oe,
  output logic                    slave_n,
  output logic                    cfgout_n,
  output logic [8*NUM_BOARDS-1:0] base_addr,
  output logic [NUM_BOARDS-1:0]   configured,
  output logic [NUM_BOARDS-1:0]   shut_up
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_CFG_READ  = 3'd2,
    S_CFG_WRITE = 3'd3,
    S_WAIT_END  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]              cur_board_q, cur_board_d;
  logic [15:0]             d_out_q, d_out_d;
  logic                    d_oe_q, d_oe_d;
  logic                    slave_n_q, slave_n_d;
  logic                    cfgout_n_q, cfgout_n_d;
  logic [8*NUM_BOARDS-1:0] base_addr_q, base_addr_d;
  logic [NUM_BOARDS-1:0]   configured_q, configured_d;
  logic [NUM_BOARDS-1:0]   shut_up_q, shut_up_d;
  logic [NUM_BOARDS-1:0]   hit;

  logic       as_s, uds_s, lds_s, rw_s, cfg_space;
  logic [6:0] word;
  logic [7:0] cur_er, cur_prod;
  logic [3:0] rd_nib;
  logic       unused_bits;

  // Synchroniser bundle order is {as, uds, lds, rw}
  assign {as_s, uds_s, lds_s, rw_s} = sync2_q;
  assign word        = a[7:1];
  assign cfg_space   = (a[23:16] == 8'hE8) && !cfgin_n && cfgout_n_q;
  assign unused_bits = ^{a[15:8], d_in[7:0]};

  function automatic logic [7:0] size_mask(input logic [2:0] sz);
    case (sz)
      3'b000:  size_mask = 8'h80;
      3'b001:  size_mask = 8'hFF;
      3'b010:  size_mask = 8'hFE;
      3'b011:  size_mask = 8'hFC;
      3'b100:  size_mask = 8'hF8;
      3'b101:  size_mask = 8'hF0;
      3'b110:  size_mask = 8'hE0;
      default: size_mask = 8'hC0;
    endcase
  endfunction

  // Only one slave_n exists, so overlapping boards collapse onto the lowest hit
  for (genvar i = 0; i < NUM_BOARDS; i++) begin : g_board
    localparam logic [7:0] MASK = size_mask(ER_TYPE[8*i+2 -: 3]);
    assign hit[i] = configured_q[i] &&
                    (((a[23:16] ^ base_addr_q[8*i +: 8]) & MASK) == 8'h00);
  end

  always_comb begin
    cur_er   = 8'h00;
    cur_prod = 8'h00;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (cur_board_q == 3'(i)) begin
        cur_er   = ER_TYPE[8*i +: 8];
        cur_prod = PRODUCT[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_nib = 4'hF;
    case (word)
      7'd0:        rd_nib = cur_er[7:4];
      7'd1:        rd_nib = cur_er[3:0];
      7'd2:        rd_nib = ~cur_prod[7:4];
      7'd3:        rd_nib = ~cur_prod[3:0];
      7'd32, 7'd33: rd_nib = 4'h0;
      default:     ;
    endcase
    for (int k = 0; k < 4; k++)
      if (word == 7'(8 + k)) rd_nib = ~MANUF[4*(3-k) +: 4];
    for (int k = 0; k < 8; k++)
      if (word == 7'(12 + k)) rd_nib = ~SERIAL[4*(7-k) +: 4];
  end

  always_comb begin
    sync1_d      = {as_n, uds_n, lds_n, rw};
    sync2_d      = sync1_q;
    state_d      = state_q;
    cur_board_d  = cur_board_q;
    d_out_d      = d_out_q;
    d_oe_d       = d_oe_q;
    cfgout_n_d   = cfgout_n_q;
    base_addr_d  = base_addr_q;
    configured_d = configured_q;
    shut_up_d    = shut_up_q;
    slave_n_d    = !((|hit) && !as_s);

    case (state_q)
      S_IDLE: begin
        if (!as_s && (!uds_s || !lds_s)) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (as_s) begin
          state_d = S_IDLE;
        end else if (cfg_space && rw_s) begin
          state_d = S_CFG_READ;
          d_oe_d  = 1'b1;
          d_out_d = {rd_nib, 12'hFFF};
        end else if (cfg_space) begin
          state_d = S_CFG_WRITE;
        end else begin
          state_d = S_WAIT_END;
        end
      end
      S_CFG_WRITE: begin
        // AS released before the write landed: drop the cycle untouched
        if (as_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_END;
          if (cfg_space && (word == 7'h24 || word == 7'h26)) begin
            for (int i = 0; i < NUM_BOARDS; i++) begin
              if (cur_board_q == 3'(i)) begin
                if (word == 7'h24) begin
                  base_addr_d[8*i +: 8] = d_in[15:8];
                  configured_d[i]       = 1'b1;
                end else begin
                  shut_up_d[i] = 1'b1;
                end
              end
            end
            cur_board_d = cur_board_q + 3'd1;
            if (cur_board_q == 3'(NUM_BOARDS - 1)) cfgout_n_d = 1'b0;
          end
        end
      end
      S_CFG_READ, S_WAIT_END: begin
        if (as_s) begin
          state_d = S_IDLE;
          d_oe_d  = 1'b0;
          d_out_d = 16'hFFFF;
        end else begin
          state_d = S_WAIT_END;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 4'hF;
      sync2_q      <= 4'hF;
      cur_board_q  <= 3'd0;
      d_out_q      <= 16'hFFFF;
      d_oe_q       <= 1'b0;
      slave_n_q    <= 1'b1;
      cfgout_n_q   <= 1'b1;
      base_addr_q  <= '0;
      configured_q <= '0;
      shut_up_q    <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cur_board_q  <= cur_board_d;
      d_out_q      <= d_out_d;
      d_oe_q       <= d_oe_d;
      slave_n_q    <= slave_n_d;
      cfgout_n_q   <= cfgout_n_d;
      base_addr_q  <= base_addr_d;
      configured_q <= configured_d;
      shut_up_q    <= shut_up_d;
    end
  end

  assign d_out      = d_out_q;
  assign d_oe       = d_oe_q;
  assign slave_n    = slave_n_q;
  assign cfgout_n   = cfgout_n_q;
  assign base_addr  = base_addr_q;
  assign configured = configured_q;
  assign shut_up    = shut_up_q;

endmodule
`default_nettype wire

// File: tb/tb_zorro2_autoconfig_multi.sv
`default_nettype none
// ============================================================================
// tb_zorro2_autoconfig_multi -- scoreboard bench for the multi-board
// autoconfig responder.  Revision: 1.0
// ============================================================================
module tb_zorro2_autoconfig_multi;
  localparam int NB = 2;

  logic          mclk = 1'b0;
  logic          reset = 1'b1;
  logic [23:1]   a = '0;
  logic          as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [15:0]   d_in = 16'h0;
  logic          cfgin_n = 1'b1;
  logic [15:0]   d_out;
  logic          d_oe, slave_n, cfgout_n;
  logic [8*NB-1:0] base_addr;
  logic [NB-1:0] configured, shut_up;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  // Board 0 and 1 both use 64K windows; product numbers differ per board
  logic [7:0] t_off [0:13] = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h10, 8'h12, 8'h14,
                               8'h16, 8'h18, 8'h26, 8'h40, 8'h42, 8'h30, 8'h44};
  logic [3:0] t_nib [0:13] = '{4'hC, 4'h1, 4'hF, 4'hE, 4'hF, 4'h7, 4'hE,
                               4'hA, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF};

  always #5 mclk = ~mclk;

  zorro2_autoconfig_multi #(
    .NUM_BOARDS (NB),
    .ER_TYPE    (16'hC1C1),
    .PRODUCT    (16'h0201),
    .MANUF      (16'h0815),
    .SERIAL     (32'h0)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .a          (a),
    .as_n       (as_n),
    .uds_n      (uds_n),
    .lds_n      (lds_n),
    .rw         (rw),
    .d_in       (d_in),
    .cfgin_n    (cfgin_n),
    .d_out      (d_out),
    .d_oe       (d_oe),
    .slave_n    (slave_n),
    .cfgout_n   (cfgout_n),
    .base_addr  (base_addr),
    .configured (configured),
    .shut_up    (shut_up)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_cycle(input logic [23:0] addr, input logic read);
    logic [23:0] ad;
    ad    = addr;
    a     = ad[23:1];
    rw    = read;
    as_n  = 1'b0;
    uds_n = 1'b0;
    lds_n = 1'b0;
  endtask

  task automatic end_cycle();
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
  endtask

  task automatic bus_read(input string tag, input logic [23:0] addr,
                          input logic [3:0] nib, input bit want_oe);
    bit seen;
    seen = 1'b0;
    @(negedge mclk);
    start_cycle(addr, 1'b1);
    if (want_oe) exp_q.push_back(nib);
    repeat (2) @(negedge mclk);
    chk({tag, "_oe_early"}, 32'(d_oe), 32'd0);
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge mclk);
      if (d_oe) begin
        seen = 1'b1;
        if (exp_q.size() == 0) chk({tag, "_unexpected"}, 32'd1, 32'd0);
        else chk(tag, 32'(d_out), 32'({exp_q.pop_front(), 12'hFFF}));
      end
    end
    chk({tag, "_oe"}, 32'(seen), 32'(want_oe));
    if (want_oe && !seen && exp_q.size() > 0) void'(exp_q.pop_front());
    end_cycle();
    repeat (3) @(negedge mclk);
    chk({tag, "_oe_off"}, 32'(d_oe), 32'd0);
    repeat (2) @(negedge mclk);
  endtask

  task automatic bus_write(input string tag, input logic [23:0] addr,
                           input logic [15:0] data, input int hold);
    bit oe_seen;
    oe_seen = 1'b0;
    @(negedge mclk);
    d_in = data;
    start_cycle(addr, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge mclk);
      if (d_oe) oe_seen = 1'b1;
    end
    end_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge mclk);
      if (d_oe) oe_seen = 1'b1;
    end
    rw = 1'b1;
    chk({tag, "_no_oe"}, 32'(oe_seen), 32'd0);
  endtask

  task automatic bus_access(input string tag, input logic [23:0] addr, input logic exp_slave_n);
    @(negedge mclk);
    start_cycle(addr, 1'b1);
    repeat (4) @(negedge mclk);
    chk(tag, 32'(slave_n), 32'(exp_slave_n));
    end_cycle();
    repeat (4) @(negedge mclk);
    chk({tag, "_rel"}, 32'(slave_n), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge mclk);
    reset = 1'b1;
    repeat (2) @(negedge mclk);
    reset = 1'b0;
  endtask

  initial begin
    bit seen;

    repeat (3) @(negedge mclk);
    reset = 1'b0;
    @(negedge mclk);
    chk("rst_d_oe", 32'(d_oe), 32'd0);
    chk("rst_d_out", 32'(d_out), 32'hFFFF);
    chk("rst_slave_n", 32'(slave_n), 32'd1);
    chk("rst_cfgout_n", 32'(cfgout_n), 32'd1);
    chk("rst_base", 32'(base_addr), 32'd0);
    chk("rst_cfg", 32'(configured), 32'd0);
    chk("rst_shut", 32'(shut_up), 32'd0);

    // Board 0 ROM contents
    cfgin_n = 1'b0;
    for (int i = 0; i < 14; i++)
      bus_read($sformatf("rd_b0_%02h", t_off[i]), {16'hE800, t_off[i]}, t_nib[i], 1'b1);

    // Chain input released: everything must freeze
    cfgin_n = 1'b1;
    bus_read("rd_cfgin_hi", 24'hE80000, 4'h0, 1'b0);
    bus_write("w48_cfgin_hi", 24'hE80048, 16'h1234, 6);
    chk("cfg_cfgin_hi", 32'(configured), 32'd0);
    cfgin_n = 1'b0;
    bus_read("rd_resume_b0", 24'hE80006, 4'hE, 1'b1);

    bus_write("w48_b0", 24'hE80048, 16'h2000, 6);
    chk("base_b0", 32'(base_addr), 32'h0020);
    chk("cfg_b0", 32'(configured), 32'b01);
    chk("cfgout_mid", 32'(cfgout_n), 32'd1);
    bus_read("rd_b1_00", 24'hE80000, 4'hC, 1'b1);
    bus_read("rd_b1_02", 24'hE80002, 4'h1, 1'b1);
    bus_read("rd_b1_06", 24'hE80006, 4'hD, 1'b1);

    // AS released before the write can land
    bus_write("w48_abort", 24'hE80048, 16'h5500, 2);
    chk("cfg_abort", 32'(configured), 32'b01);
    chk("base_abort", 32'(base_addr), 32'h0020);

    bus_write("w4a_b1", 24'hE8004A, 16'h7700, 6);
    chk("cfg_4a", 32'(configured), 32'b01);

    bus_write("w48_b1", 24'hE80048, 16'hE900, 6);
    chk("base_b1", 32'(base_addr), 32'hE920);
    chk("cfg_b1", 32'(configured), 32'b11);
    chk("cfgout_done", 32'(cfgout_n), 32'd0);
    bus_read("rd_after_done", 24'hE80000, 4'h0, 1'b0);

    bus_access("sl_200000", 24'h200000, 1'b0);
    bus_access("sl_20fffe", 24'h20FFFE, 1'b0);
    bus_access("sl_e90000", 24'hE90000, 1'b0);
    bus_access("sl_300000", 24'h300000, 1'b1);
    bus_access("sl_210000", 24'h210000, 1'b1);

    // Shut-up on board 0
    do_reset();
    bus_write("w4c_b0", 24'hE8004C, 16'h2000, 6);
    chk("shut_b0", 32'(shut_up), 32'b01);
    chk("shut_base", 32'(base_addr), 32'd0);
    chk("shut_cfg", 32'(configured), 32'd0);
    bus_access("sl_shut_000000", 24'h000000, 1'b1);
    bus_access("sl_shut_200000", 24'h200000, 1'b1);

    // Reset while a config read is driving the bus
    do_reset();
    bus_write("w48_pre_rst", 24'hE80048, 16'h2000, 6);
    @(negedge mclk);
    start_cycle(24'hE80000, 1'b1);
    exp_q.push_back(4'hC);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge mclk);
      if (d_oe) begin
        seen = 1'b1;
        chk("rd_pre_rst", 32'(d_out), 32'({exp_q.pop_front(), 12'hFFF}));
      end
    end
    chk("rd_pre_rst_oe", 32'(seen), 32'd1);
    if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
    reset = 1'b1;
    @(negedge mclk);
    chk("midrst_d_oe", 32'(d_oe), 32'd0);
    chk("midrst_cfg", 32'(configured), 32'd0);
    chk("midrst_cfgout", 32'(cfgout_n), 32'd1);
    end_cycle();
    repeat (2) @(negedge mclk);
    reset = 1'b0;
    bus_read("rd_post_rst", 24'hE80002, 4'h1, 1'b1);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
